// File: rtl/dth_poll_scheduler.sv
// DTH sensor poll scheduler: paces read starts (power-up, period, minimum gap, on demand),
// guards each read with a watchdog, verifies the checksum, retries, and holds the last good reading.
module dth_poll_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int POWERUP_MS = 1000,
  parameter int PERIOD_MS  = 2000,
  parameter int MIN_GAP_MS = 1000,
  parameter int TIMEOUT_MS = 25,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_now,
  input  logic        rd_done,
  input  logic        rd_error,
  input  logic [39:0] rd_data,
  output logic        rd_start,
  output logic [15:0] hum,
  output logic [15:0] temp,
  output logic        data_valid,
  output logic        busy,
  output logic [7:0]  err_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_WAIT    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_RD = 3'd3,
    S_CHECK   = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  localparam int          TICK_DIV    = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam logic [31:0] TICK_LAST   = 32'(TICK_DIV - 1);
  localparam logic [31:0] POWERUP_W   = 32'(POWERUP_MS);
  localparam logic [31:0] PERIOD_W    = 32'(PERIOD_MS);
  localparam logic [31:0] MIN_GAP_W   = 32'(MIN_GAP_MS);
  localparam logic [31:0] TIMEOUT_W   = 32'(TIMEOUT_MS);
  localparam logic [7:0]  MAX_RETRY_W = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] elapsed_q, elapsed_d;
  logic [31:0] watchdog_q, watchdog_d;
  logic [7:0]  retry_q, retry_d;
  logic        req_pend_q, req_pend_d;
  logic [39:0] frame_q, frame_d;
  logic [15:0] hum_q, hum_d;
  logic [15:0] temp_q, temp_d;
  logic        data_valid_q, data_valid_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        tick;
  logic [7:0]  sum;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    elapsed_d    = elapsed_q;
    watchdog_d   = watchdog_q;
    retry_d      = retry_q;
    req_pend_d   = req_pend_q | req_now;
    frame_d      = frame_q;
    hum_d        = hum_q;
    temp_d       = temp_q;
    data_valid_d = data_valid_q;
    err_cnt_d    = err_cnt_q;

    tick = (presc_q >= TICK_LAST);
    sum  = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

    if (tick) begin
      presc_d    = '0;
      elapsed_d  = (elapsed_q == '1) ? elapsed_q : elapsed_q + 32'd1;
      watchdog_d = (watchdog_q == '1) ? watchdog_q : watchdog_q + 32'd1;
    end else begin
      presc_d = presc_q + 32'd1;
    end

    case (state_q)
      S_BOOT: begin
        if (elapsed_q >= POWERUP_W) state_d = S_ISSUE;
      end
      S_WAIT: begin
        if ((elapsed_q >= PERIOD_W) ||
            ((elapsed_q >= MIN_GAP_W) && (req_pend_q || (retry_q != 8'd0))))
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        elapsed_d  = '0;
        watchdog_d = '0;
        presc_d    = '0;
        req_pend_d = 1'b0;
        state_d    = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        // A protocol error outranks a frame arriving in the same cycle.
        if (rd_error || (watchdog_q >= TIMEOUT_W)) begin
          state_d = S_FAIL;
        end else if (rd_done) begin
          frame_d = rd_data;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sum == frame_q[7:0]) begin
          hum_d        = frame_q[39:24];
          temp_d       = frame_q[23:8];
          data_valid_d = 1'b1;
          retry_d      = 8'd0;
          state_d      = S_WAIT;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_FAIL: begin
        err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        // Giving up keeps the stale reading visible but flags it invalid.
        if (retry_q + 8'd1 >= MAX_RETRY_W) begin
          data_valid_d = 1'b0;
          retry_d      = 8'd0;
        end else begin
          retry_d = retry_q + 8'd1;
        end
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      presc_q      <= '0;
      elapsed_q    <= '0;
      watchdog_q   <= '0;
      retry_q      <= '0;
      req_pend_q   <= 1'b0;
      frame_q      <= '0;
      hum_q        <= '0;
      temp_q       <= '0;
      data_valid_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      elapsed_q    <= elapsed_d;
      watchdog_q   <= watchdog_d;
      retry_q      <= retry_d;
      req_pend_q   <= req_pend_d;
      frame_q      <= frame_d;
      hum_q        <= hum_d;
      temp_q       <= temp_d;
      data_valid_q <= data_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rd_start   = (state_q == S_ISSUE);
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT_RD) || (state_q == S_CHECK);
  assign state      = state_q;
  assign hum        = hum_q;
  assign temp       = temp_q;
  assign data_valid = data_valid_q;
  assign err_cnt    = err_cnt_q;

endmodule
